// File: rtl/mod_counter_sync.sv
// Programmable modulo event/period counter: counts 0..limit with up/down direction,
// wrap or one-shot end-of-range, parallel load, terminal pulse and a saturating wrap count.
module mod_counter_sync #(
    parameter int WIDTH       = 4,
    parameter int RESET_LIMIT = 9,
    parameter int WRAP_W      = 8
) (
    input  logic              clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_clr,
    input  logic              i_load,
    input  logic [WIDTH-1:0]  i_load_val,
    input  logic              i_dir,
    input  logic              i_mode,
    input  logic              i_limit_wr,
    input  logic [WIDTH-1:0]  i_limit,
    output logic [WIDTH-1:0]  o_count,
    output logic              o_tc,
    output logic              o_done,
    output logic [WRAP_W-1:0] o_wraps,
    output logic [WIDTH-1:0]  o_limit
);

    logic [WIDTH-1:0]  count_q;
    logic              tc_q;
    logic              done_q;
    logic [WRAP_W-1:0] wraps_q;
    logic [WIDTH-1:0]  limit_q;
    logic              at_end;

    // Up uses >= so a loaded value above the limit ends on the next step.
    assign at_end = i_dir ? (count_q >= limit_q) : (count_q == '0);

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            done_q  <= 1'b0;
            wraps_q <= '0;
            limit_q <= WIDTH'(RESET_LIMIT);
        end else begin
            tc_q <= 1'b0;
            if (i_limit_wr) begin
                limit_q <= i_limit;
            end
            if (i_clr) begin
                count_q <= '0;
                done_q  <= 1'b0;
                wraps_q <= '0;
            end else if (i_load) begin
                count_q <= i_load_val;
                done_q  <= 1'b0;
            end else if (i_en && !done_q) begin
                if (at_end) begin
                    tc_q <= 1'b1;
                    if (wraps_q != {WRAP_W{1'b1}}) begin
                        wraps_q <= wraps_q + 1'b1;
                    end
                    if (i_mode) begin
                        done_q <= 1'b1;
                    end else begin
                        count_q <= i_dir ? '0 : limit_q;
                    end
                end else begin
                    count_q <= i_dir ? count_q + 1'b1 : count_q - 1'b1;
                end
            end
        end
    end

    assign o_count = count_q;
    assign o_tc    = tc_q;
    assign o_done  = done_q;
    assign o_wraps = wraps_q;
    assign o_limit = limit_q;

endmodule

// File: tb/tb_mod_counter_sync.sv
// Self-checking bench for mod_counter_sync: directed scenarios plus random steps,
// expected state queued at drive time and compared one cycle later.
module tb_mod_counter_sync;

    logic       clk = 1'b0;
    logic       i_rst;
    logic       i_en, i_clr, i_load, i_dir, i_mode, i_limit_wr;
    logic [3:0] i_load_val, i_limit;
    logic [3:0] o_count, o_limit, o_count2, o_limit2;
    logic       o_tc, o_done, o_tc2, o_done2;
    logic [7:0] o_wraps;
    logic [1:0] o_wraps2;

    int n_checks = 0;
    int n_errors = 0;
    int tc_seen  = 0;

    int m_count, m_tc, m_done, m_wraps, m_wraps2, m_limit;
    logic [19:0] exp_q[$];

    always #5 clk = ~clk;

    mod_counter_sync #(.WIDTH(4), .RESET_LIMIT(9), .WRAP_W(8)) dut (
        .clk(clk), .i_rst(i_rst), .i_en(i_en), .i_clr(i_clr), .i_load(i_load),
        .i_load_val(i_load_val), .i_dir(i_dir), .i_mode(i_mode),
        .i_limit_wr(i_limit_wr), .i_limit(i_limit),
        .o_count(o_count), .o_tc(o_tc), .o_done(o_done), .o_wraps(o_wraps), .o_limit(o_limit)
    );

    mod_counter_sync #(.WIDTH(4), .RESET_LIMIT(9), .WRAP_W(2)) dut2 (
        .clk(clk), .i_rst(i_rst), .i_en(i_en), .i_clr(i_clr), .i_load(i_load),
        .i_load_val(i_load_val), .i_dir(i_dir), .i_mode(i_mode),
        .i_limit_wr(i_limit_wr), .i_limit(i_limit),
        .o_count(o_count2), .o_tc(o_tc2), .o_done(o_done2), .o_wraps(o_wraps2), .o_limit(o_limit2)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_count = 0; m_tc = 0; m_done = 0; m_wraps = 0; m_wraps2 = 0; m_limit = 9;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_count"}, int'(o_count), 0);
        check({tag, "_tc"},    int'(o_tc),    0);
        check({tag, "_done"},  int'(o_done),  0);
        check({tag, "_wraps"}, int'(o_wraps), 0);
        check({tag, "_limit"}, int'(o_limit), 9);
    endtask

    // Drive one cycle of controls, queue the expected post-edge state, then compare.
    task automatic step(input logic en, input logic dir, input logic mode, input logic clr,
                        input logic load, input int lv, input logic wr, input int lim);
        logic [19:0] e;
        int          cur_lim;
        logic        term;
        i_en = en; i_dir = dir; i_mode = mode; i_clr = clr; i_load = load;
        i_load_val = 4'(lv); i_limit_wr = wr; i_limit = 4'(lim);
        cur_lim = m_limit;
        term    = dir ? (m_count >= cur_lim) : (m_count == 0);
        m_tc    = 0;
        if (clr) begin
            m_count = 0; m_done = 0; m_wraps = 0; m_wraps2 = 0;
        end else if (load) begin
            m_count = lv; m_done = 0;
        end else if (en && m_done == 0) begin
            if (term) begin
                m_tc = 1;
                if (m_wraps < 255) m_wraps++;
                if (m_wraps2 < 3) m_wraps2++;
                if (mode) m_done = 1;
                else m_count = dir ? 0 : cur_lim;
            end else begin
                m_count = dir ? (m_count + 1) % 16 : m_count - 1;
            end
        end
        if (wr) m_limit = lim;
        exp_q.push_back({4'(m_count), 1'(m_tc), 1'(m_done), 8'(m_wraps), 2'(m_wraps2), 4'(m_limit)});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("count",  int'(o_count),  int'(e[19:16]));
        check("tc",     int'(o_tc),     int'(e[15]));
        check("done",   int'(o_done),   int'(e[14]));
        check("wraps",  int'(o_wraps),  int'(e[13:6]));
        check("wraps2", int'(o_wraps2), int'(e[5:4]));
        check("limit",  int'(o_limit),  int'(e[3:0]));
        tc_seen += int'(o_tc);
    endtask

    task automatic idle_inputs();
        i_en = 0; i_clr = 0; i_load = 0; i_dir = 1; i_mode = 0;
        i_limit_wr = 0; i_load_val = 0; i_limit = 0;
    endtask

    initial begin
        idle_inputs();
        model_reset();
        i_rst = 1'b1;
        #12;
        check_reset_vals("rst");
        @(posedge clk); #1;
        i_rst = 1'b0;
        check_reset_vals("rst_hold");

        // 1: up, wrap, limit 9 -> 0..9,0..9,0..4
        tc_seen = 0;
        for (int i = 0; i < 24; i++) step(1, 1, 0, 0, 0, 0, 0, 0);
        check("t1_count", int'(o_count), 4);
        check("t1_wraps", int'(o_wraps), 2);
        check("t1_tc_pulses", tc_seen, 2);

        // 2: down from 0 wraps to 9, then reverse direction
        step(0, 1, 0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        check("t2_first_down", int'(o_count), 9);
        check("t2_first_tc", int'(o_tc), 1);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0, 0, 0);
        check("t2_mid", int'(o_count), 5);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        check("t2_turn", int'(o_count), 6);
        step(1, 1, 0, 0, 0, 0, 0, 0);

        // 3: one-shot up to 5, then frozen
        step(0, 1, 1, 1, 0, 0, 1, 5);
        for (int i = 0; i < 5; i++) step(1, 1, 1, 0, 0, 0, 0, 0);
        check("t3_top", int'(o_count), 5);
        tc_seen = 0;
        step(1, 1, 1, 0, 0, 0, 0, 0);
        check("t3_done", int'(o_done), 1);
        for (int i = 0; i < 10; i++) step(1, 1, 1, 0, 0, 0, 0, 0);
        check("t3_hold", int'(o_count), 5);
        check("t3_wraps", int'(o_wraps), 1);
        check("t3_one_pulse", tc_seen, 1);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        check("t3_wrapmode_keeps_done", int'(o_done), 1);
        step(0, 1, 1, 1, 0, 0, 0, 0);
        check("t3_clr_count", int'(o_count), 0);
        check("t3_clr_done", int'(o_done), 0);

        // 4: load above limit, then clr beats load
        step(0, 1, 0, 0, 1, 12, 1, 9);
        check("t4_load", int'(o_count), 12);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        check("t4_over_count", int'(o_count), 0);
        check("t4_over_tc", int'(o_tc), 1);
        step(0, 1, 0, 0, 1, 13, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        check("t4_over_down", int'(o_count), 12);
        step(1, 1, 0, 1, 1, 7, 0, 0);
        check("t4_clr_wins", int'(o_count), 0);

        // 5: limit change on the same edge as a step
        step(0, 1, 0, 0, 1, 7, 0, 0);
        step(1, 1, 0, 0, 0, 0, 1, 3);
        check("t5_old_limit", int'(o_count), 8);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        check("t5_term", int'(o_count), 0);
        check("t5_term_tc", int'(o_tc), 1);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0, 0, 0, 0);
        check("t5_cycle", int'(o_count), 0);

        // full-range limit wraps cleanly
        step(0, 1, 0, 1, 0, 0, 1, 15);
        for (int i = 0; i < 15; i++) step(1, 1, 0, 0, 0, 0, 0, 0);
        check("full_top", int'(o_count), 15);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        check("full_wrap", int'(o_count), 0);
        check("full_tc", int'(o_tc), 1);

        // 6: asynchronous reset between edges
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0, 0, 0);
        #2;
        i_rst = 1'b1;
        #1;
        check_reset_vals("arst");
        model_reset();
        @(posedge clk); #1;
        i_rst = 1'b0;
        idle_inputs();
        step(0, 1, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 6; i++) step(1, 1, 0, 0, 0, 0, 0, 0);
        check("t6_sat", int'(o_wraps2), 3);
        check("t6_nosat", int'(o_wraps), 6);
        check("t6_tc_high", int'(o_tc), 1);
        check("t6_count0", int'(o_count), 0);

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 9) < 8), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 11) == 0), $urandom_range(0, 15),
                 ($urandom_range(0, 15) == 0), $urandom_range(0, 15));
        end

        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
